// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: registered PC with prioritised exception/branch/jump
// redirects, stall hold and a one-entry pending-redirect buffer.
module pc_next_unit #(
  parameter int                ADDR_W    = 12,
  parameter int                STEP      = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(12'h080)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              exc_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              jmp_valid_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o,
  output logic              pend_o,
  output logic              flush_o
);

  localparam logic [1:0] RANK_BR  = 2'd2;
  localparam logic [1:0] RANK_JMP = 2'd1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_vld;
  logic [1:0]        r_pend_rank;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_flush;

  logic [ADDR_W-1:0] w_npc;
  logic              w_new_vld;
  logic [1:0]        w_new_rank;
  logic [ADDR_W-1:0] w_new_addr;
  logic              w_new_beats_pend;

  // Sequential address wraps silently at 2^ADDR_W.
  assign w_npc = r_pc + ADDR_W'(STEP);

  // A branch outranks a jump raised in the same cycle.
  always_comb begin
    w_new_vld  = br_valid_i | jmp_valid_i;
    w_new_rank = RANK_JMP;
    w_new_addr = jmp_addr_i;
    if (br_valid_i) begin
      w_new_rank = RANK_BR;
      w_new_addr = br_addr_i;
    end
  end

  // Ties go to the newer redirect, both when buffering and when releasing.
  assign w_new_beats_pend = w_new_vld && (!r_pend_vld || (w_new_rank >= r_pend_rank));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_pend_vld  <= 1'b0;
      r_pend_rank <= 2'd0;
      r_pend_addr <= '0;
      r_flush     <= 1'b0;
    end else if (exc_i) begin
      r_pc       <= EXC_VEC;
      r_pend_vld <= 1'b0;
      r_flush    <= 1'b1;
    end else if (stall_i) begin
      r_flush <= 1'b0;
      if (w_new_beats_pend) begin
        r_pend_vld  <= 1'b1;
        r_pend_rank <= w_new_rank;
        r_pend_addr <= w_new_addr;
      end
    end else begin
      r_pend_vld <= 1'b0;
      if (w_new_beats_pend) begin
        r_pc    <= w_new_addr;
        r_flush <= 1'b1;
      end else if (r_pend_vld) begin
        r_pc    <= r_pend_addr;
        r_flush <= 1'b1;
      end else begin
        r_pc    <= w_npc;
        r_flush <= 1'b0;
      end
    end
  end

  assign pc_o    = r_pc;
  assign npc_o   = w_npc;
  assign pend_o  = r_pend_vld;
  assign flush_o = r_flush;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit (ADDR_W=12, STEP=1, RESET_VEC=0, EXC_VEC=0x080).
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, exc_i, br_valid_i, jmp_valid_i;
  logic [11:0] br_addr_i, jmp_addr_i;
  logic [11:0] pc_o, npc_o;
  logic        pend_o, flush_o;

  int checks   = 0;
  int failures = 0;

  pc_next_unit #(
    .ADDR_W(12), .STEP(1), .RESET_VEC(12'h000), .EXC_VEC(12'h080)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .exc_i(exc_i),
    .br_valid_i(br_valid_i), .br_addr_i(br_addr_i),
    .jmp_valid_i(jmp_valid_i), .jmp_addr_i(jmp_addr_i),
    .pc_o(pc_o), .npc_o(npc_o), .pend_o(pend_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; exc_i = 0; br_valid_i = 0; jmp_valid_i = 0;
  endtask

  initial begin
    rst_n = 0; br_addr_i = '0; jmp_addr_i = '0;
    idle();
    #3;
    check("rst_pc", pc_o, 12'h000);
    check("rst_npc", npc_o, 12'h001);
    check("rst_pend", pend_o, 0);
    check("rst_flush", flush_o, 0);
    #4 rst_n = 1;

    // Sequential count 0..4
    check("seq_pc0", pc_o, 12'h000);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("seq_pc%0d", i), pc_o, 12'(i));
      check($sformatf("seq_flush%0d", i), flush_o, 0);
    end

    // Wrap at all-ones
    br_valid_i = 1; br_addr_i = 12'hFFE;
    tick(); idle();
    check("wrap_pc_ffe", pc_o, 12'hFFE);
    check("wrap_flush", flush_o, 1);
    tick();
    check("wrap_pc_fff", pc_o, 12'hFFF);
    check("wrap_npc", npc_o, 12'h000);
    check("wrap_flush_off", flush_o, 0);
    tick();
    check("wrap_pc_000", pc_o, 12'h000);

    // Branch beats jump in the same cycle
    jmp_valid_i = 1; jmp_addr_i = 12'h00A;
    tick(); idle();
    check("prio_setup", pc_o, 12'h00A);
    br_valid_i = 1; br_addr_i = 12'h200; jmp_valid_i = 1; jmp_addr_i = 12'h300;
    tick(); idle();
    check("prio_pc", pc_o, 12'h200);
    check("prio_flush", flush_o, 1);
    tick();
    check("prio_pc_next", pc_o, 12'h201);
    check("prio_flush_off", flush_o, 0);

    // Stalled redirect: jump then higher-rank branch buffered
    jmp_valid_i = 1; jmp_addr_i = 12'h020;
    tick(); idle();
    check("stall_setup", pc_o, 12'h020);
    stall_i = 1; jmp_valid_i = 1; jmp_addr_i = 12'h150;
    tick();
    check("stall1_pc", pc_o, 12'h020);
    check("stall1_pend", pend_o, 1);
    check("stall1_flush", flush_o, 0);
    jmp_valid_i = 0; br_valid_i = 1; br_addr_i = 12'h0A0;
    tick();
    br_valid_i = 0;
    check("stall2_pc", pc_o, 12'h020);
    tick();
    check("stall3_pc", pc_o, 12'h020);
    check("stall3_pend", pend_o, 1);
    stall_i = 0;
    tick();
    check("release_pc", pc_o, 12'h0A0);
    check("release_flush", flush_o, 1);
    check("release_pend", pend_o, 0);

    // Exception overrides a pending branch while stalled
    stall_i = 1; br_valid_i = 1; br_addr_i = 12'h300;
    tick();
    br_valid_i = 0;
    check("exc_pend_set", pend_o, 1);
    check("exc_hold_pc", pc_o, 12'h0A0);
    exc_i = 1;
    tick();
    exc_i = 0;
    check("exc_pc", pc_o, 12'h080);
    check("exc_pend", pend_o, 0);
    check("exc_flush", flush_o, 1);
    tick();
    check("exc_stall_pc", pc_o, 12'h080);
    check("exc_stall_flush", flush_o, 0);
    stall_i = 0;
    tick();
    check("exc_after1", pc_o, 12'h081);
    check("exc_after1_flush", flush_o, 0);
    tick();
    check("exc_after2", pc_o, 12'h082);

    // Lower-rank jump dropped while a branch is pending
    stall_i = 1; br_valid_i = 1; br_addr_i = 12'h060;
    tick(); idle(); stall_i = 1;
    jmp_valid_i = 1; jmp_addr_i = 12'h070;
    tick(); idle();
    check("drop_hold_pc", pc_o, 12'h082);
    tick();
    check("drop_pc", pc_o, 12'h060);
    check("drop_flush", flush_o, 1);

    // Pending branch beats a new jump at release; equal rank goes to the new one
    stall_i = 1; br_valid_i = 1; br_addr_i = 12'h0C0;
    tick(); idle();
    jmp_valid_i = 1; jmp_addr_i = 12'h0D0;
    tick(); idle();
    check("pend_wins_pc", pc_o, 12'h0C0);
    stall_i = 1; jmp_valid_i = 1; jmp_addr_i = 12'h040;
    tick(); idle();
    jmp_valid_i = 1; jmp_addr_i = 12'h050;
    tick(); idle();
    check("tie_new_pc", pc_o, 12'h050);
    check("tie_new_pend", pend_o, 0);

    // Asynchronous reset mid-stall with a pending entry
    stall_i = 1; br_valid_i = 1; br_addr_i = 12'h123;
    tick();
    br_valid_i = 0;
    check("areset_pend_pre", pend_o, 1);
    #1 rst_n = 0;
    #1;
    check("areset_pc", pc_o, 12'h000);
    check("areset_pend", pend_o, 0);
    check("areset_flush", flush_o, 0);
    #1 rst_n = 1;
    idle();
    tick();
    check("areset_seq1", pc_o, 12'h001);
    tick();
    check("areset_seq2", pc_o, 12'h002);
    check("areset_no_flush", flush_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
